// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: MEM-stage SRAM bus controller running setup/strobe/hold cycles and stalling the pipeline until done
module ram_access_ctrl #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    state_t state;
    logic op_we;
    logic [3:0] cnt;
    assign stall = req_valid & ~done & ~rst;
    // Bus strobes are set on the edge entering each state so they always match it
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_we       <= 1'b0;
            cnt         <= '0;
            done        <= 1'b0;
            rdata       <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    state       <= SETUP;
                    sram_addr   <= req_addr;
                    sram_dq_out <= req_wdata;
                    op_we       <= req_we;
                    sram_ce_n   <= 1'b0;
                    sram_dq_oe  <= req_we;
                end
                SETUP: begin
                    state     <= STROBE;
                    cnt       <= 4'(WAIT_CYCLES - 1);
                    sram_we_n <= ~op_we;
                    sram_oe_n <= op_we;
                end
                STROBE: if (cnt == '0) begin
                    state     <= HOLD;
                    sram_we_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    done      <= 1'b1;
                    if (!op_we) rdata <= sram_dq_in;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                HOLD: begin
                    state      <= IDLE;
                    sram_ce_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    done       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed bench for two controllers (WAIT_CYCLES 1 and 3), each with its own small SRAM model
module tb_ram_access_ctrl;
    logic clk = 1'b0, rst;
    logic rv_a, rwe_a, rv_b, rwe_b;
    logic [15:0] raddr_a, rwd_a, raddr_b, rwd_b;
    logic stall_a, done_a, soe_a, ce_a, oe_a, we_a;
    logic stall_b, done_b, soe_b, ce_b, oe_b, we_b;
    logic [15:0] rdata_a, saddr_a, sdo_a, sdi_a;
    logic [15:0] rdata_b, saddr_b, sdo_b, sdi_b;
    logic [15:0] mem_a [0:255];
    logic [15:0] mem_b [0:255];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    ram_access_ctrl #(.WAIT_CYCLES(1)) u_a (
        .clk(clk), .rst(rst), .req_valid(rv_a), .req_we(rwe_a), .req_addr(raddr_a), .req_wdata(rwd_a),
        .stall(stall_a), .done(done_a), .rdata(rdata_a), .sram_addr(saddr_a), .sram_dq_out(sdo_a),
        .sram_dq_oe(soe_a), .sram_dq_in(sdi_a), .sram_ce_n(ce_a), .sram_oe_n(oe_a), .sram_we_n(we_a));
    ram_access_ctrl #(.WAIT_CYCLES(3)) u_b (
        .clk(clk), .rst(rst), .req_valid(rv_b), .req_we(rwe_b), .req_addr(raddr_b), .req_wdata(rwd_b),
        .stall(stall_b), .done(done_b), .rdata(rdata_b), .sram_addr(saddr_b), .sram_dq_out(sdo_b),
        .sram_dq_oe(soe_b), .sram_dq_in(sdi_b), .sram_ce_n(ce_b), .sram_oe_n(oe_b), .sram_we_n(we_b));

    assign sdi_a = (!ce_a && !oe_a) ? mem_a[saddr_a[7:0]] : 16'h0BAD;
    assign sdi_b = (!ce_b && !oe_b) ? mem_b[saddr_b[7:0]] : 16'h0BAD;
    always @(posedge clk) begin
        if (!ce_a && !we_a) mem_a[saddr_a[7:0]] <= sdo_a;
        if (!ce_b && !we_b) mem_b[saddr_b[7:0]] <= sdo_b;
    end

    task automatic test_reset;
        rst = 1'b1; rv_a = 1'b1; rwe_a = 1'b1; raddr_a = 16'h0042; rwd_a = 16'h9999;
        rv_b = 1'b1; rwe_b = 1'b0; raddr_b = 16'h0042; rwd_b = 16'h9999;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({stall_a, done_a, ce_a, oe_a, we_a, soe_a} !== 6'b001110) begin
            errors++; $display("FAIL reset_ctrl_a got %b want 001110", {stall_a, done_a, ce_a, oe_a, we_a, soe_a});
        end
        checks++;
        if ({stall_b, done_b, ce_b, oe_b, we_b, soe_b} !== 6'b001110) begin
            errors++; $display("FAIL reset_ctrl_b got %b want 001110", {stall_b, done_b, ce_b, oe_b, we_b, soe_b});
        end
        checks++;
        if ({rdata_a, saddr_a, sdo_a, rdata_b, saddr_b, sdo_b} !== 96'h0) begin
            errors++; $display("FAIL reset_data got %h want 0", {rdata_a, saddr_a, sdo_a, rdata_b, saddr_b, sdo_b});
        end
        @(posedge clk); #1;
        rst = 1'b0; rv_a = 1'b0; rv_b = 1'b0;
    endtask

    task automatic test_store;
        logic [5:0] exp_v [0:4] = '{6'b101110, 6'b100111, 6'b100101, 6'b010111, 6'b001110};
        @(posedge clk); #1;
        rv_a = 1'b1; rwe_a = 1'b1; raddr_a = 16'h1234; rwd_a = 16'hBEEF;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (c == 4) rv_a = 1'b0;
            end
            @(negedge clk);
            checks++;
            if ({stall_a, done_a, ce_a, oe_a, we_a, soe_a} !== exp_v[c]) begin
                errors++; $display("FAIL store_c%0d got %b want %b", c, {stall_a, done_a, ce_a, oe_a, we_a, soe_a}, exp_v[c]);
            end
            if (c == 1) begin
                checks++;
                if ({saddr_a, sdo_a} !== 32'h1234BEEF) begin
                    errors++; $display("FAIL store_bus got %h want 1234beef", {saddr_a, sdo_a});
                end
            end
        end
        checks++;
        if (mem_a[8'h34] !== 16'hBEEF) begin
            errors++; $display("FAIL store_mem got %h want beef", mem_a[8'h34]);
        end
    endtask

    task automatic test_load;
        logic [5:0] exp_v [0:6] = '{6'b101110, 6'b100110, 6'b100010, 6'b100010, 6'b100010, 6'b010110, 6'b001110};
        logic [15:0] exp_r [0:6] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hA5C3, 16'hA5C3};
        mem_b[8'hF0] = 16'hA5C3;
        @(posedge clk); #1;
        rv_b = 1'b1; rwe_b = 1'b0; raddr_b = 16'h00F0; rwd_b = 16'h0000;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (c == 6) rv_b = 1'b0;
            end
            @(negedge clk);
            checks++;
            if ({stall_b, done_b, ce_b, oe_b, we_b, soe_b} !== exp_v[c] || rdata_b !== exp_r[c]) begin
                errors++; $display("FAIL load_c%0d got %b/%h want %b/%h", c, {stall_b, done_b, ce_b, oe_b, we_b, soe_b}, rdata_b, exp_v[c], exp_r[c]);
            end
        end
        @(negedge clk);
        checks++;
        if (rdata_b !== 16'hA5C3 || saddr_b !== 16'h00F0) begin
            errors++; $display("FAIL load_hold got %h/%h want a5c3/00f0", rdata_b, saddr_b);
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] exp_v;
        int t;
        @(posedge clk); #1;
        rv_b = 1'b1; rwe_b = 1'b1; raddr_b = 16'h0010; rwd_b = 16'h1111;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (c == 6) begin rwe_b = 1'b0; rwd_b = 16'h7777; end
                if (c == 12) rv_b = 1'b0;
            end
            @(negedge clk);
            t = (c < 6) ? c : c - 6;
            exp_v = (c == 12) ? 6'b001110 :
                    {t <= 4, t == 5, !(t >= 1 && t <= 5), !(c >= 8 && c <= 10), !(c >= 2 && c <= 4), c >= 1 && c <= 5};
            checks++;
            if ({stall_b, done_b, ce_b, oe_b, we_b, soe_b} !== exp_v) begin
                errors++; $display("FAIL b2b_c%0d got %b want %b", c, {stall_b, done_b, ce_b, oe_b, we_b, soe_b}, exp_v);
            end
            checks++;
            if (soe_b === 1'b1 && oe_b === 1'b0) begin
                errors++; $display("FAIL b2b_overlap_c%0d got dq_oe=1 oe_n=0 want never both", c);
            end
            if (c == 5 || c == 11) begin
                checks++;
                if (rdata_b !== ((c == 5) ? 16'hA5C3 : 16'h1111)) begin
                    errors++; $display("FAIL b2b_rdata_c%0d got %h want %h", c, rdata_b, (c == 5) ? 16'hA5C3 : 16'h1111);
                end
            end
        end
    endtask

    task automatic test_reset_mid_strobe;
        logic [5:0] exp_v [0:6] = '{6'b101110, 6'b100111, 6'b000101, 6'b001110, 6'b001110, 6'b101110, 6'b100111};
        @(posedge clk); #1;
        rv_a = 1'b1; rwe_a = 1'b1; raddr_a = 16'h0055; rwd_a = 16'h5555;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (c == 2) rst = 1'b1;
                if (c == 3) begin rst = 1'b0; rv_a = 1'b0; end
                if (c == 5) begin rv_a = 1'b1; raddr_a = 16'h0066; end
            end
            @(negedge clk);
            checks++;
            if ({stall_a, done_a, ce_a, oe_a, we_a, soe_a} !== exp_v[c]) begin
                errors++; $display("FAIL rst_mid_c%0d got %b want %b", c, {stall_a, done_a, ce_a, oe_a, we_a, soe_a}, exp_v[c]);
            end
        end
        @(posedge clk); #1;
        rv_a = 1'b0;
    endtask

    task automatic test_flush;
        logic [5:0] exp_v [0:7] = '{6'b101110, 6'b000110, 6'b000010, 6'b100010, 6'b100010, 6'b010110, 6'b101110, 6'b100111};
        int n;
        @(posedge clk); #1;
        rv_b = 1'b1; rwe_b = 1'b0; raddr_b = 16'h0010; rwd_b = 16'h0000;
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (c == 1) begin rv_b = 1'b0; rwe_b = 1'b1; raddr_b = 16'hFFFF; end
                if (c == 3) begin rv_b = 1'b1; rwe_b = 1'b1; raddr_b = 16'h0020; rwd_b = 16'h2222; end
            end
            @(negedge clk);
            checks++;
            if ({stall_b, done_b, ce_b, oe_b, we_b, soe_b} !== exp_v[c]) begin
                errors++; $display("FAIL flush_c%0d got %b want %b", c, {stall_b, done_b, ce_b, oe_b, we_b, soe_b}, exp_v[c]);
            end
            if (c == 5 || c == 7) begin
                checks++;
                if (saddr_b !== ((c == 5) ? 16'h0010 : 16'h0020) || (c == 5 && rdata_b !== 16'h1111)) begin
                    errors++; $display("FAIL flush_bus_c%0d got addr %h rdata %h", c, saddr_b, rdata_b);
                end
            end
        end
        n = 0;
        while (done_b !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_b !== 1'b1) begin
            errors++; $display("FAIL flush_store_done got timeout after %0d cycles want done", n);
        end
        @(posedge clk); #1;
        rv_b = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_b[8'h20] !== 16'h2222) begin
            errors++; $display("FAIL flush_store_mem got %h want 2222", mem_b[8'h20]);
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_back_to_back();
        test_reset_mid_strobe();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- MEM-stage controller for the external 16-bit SRAM. It sits directly downstream of the RAM data mux.
- Takes one load/store request per pipeline slot: address, write data (the mux output) and direction.
- Runs a multi-cycle SRAM bus cycle: setup, strobe, hold.
- Stalls the pipeline until the access completes and returns registered read data to MEM/WB.

Parameters:
WAIT_CYCLES, 1, cycles the strobe (we_n/oe_n) is held low; legal range 1..15
ADDR_W, 16, SRAM address width
DATA_W, 16, SRAM data width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
req_valid  in  1  MEM stage holds a load/store this cycle
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  access address
req_wdata  in  DATA_W  store data from RAM data mux
stall  out  1  freeze pipeline; combinational
done  out  1  one-cycle pulse: access complete
rdata  out  DATA_W  load result, registered
sram_addr  out  ADDR_W  SRAM address, registered
sram_dq_out  out  DATA_W  SRAM write data, registered
sram_dq_oe  out  1  1 = drive data bus (top-level tristate enable)
sram_dq_in  in  DATA_W  SRAM read data
sram_ce_n  out  1  chip enable, active-low
sram_oe_n  out  1  output enable, active-low
sram_we_n  out  1  write enable, active-low

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state IDLE; sram_ce_n/oe_n/we_n = 1; sram_dq_oe = 0; sram_addr = 0; sram_dq_out = 0; rdata = 0; done = 0; wait counter = 0. stall is forced to 0 while rst = 1.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE, req_valid = 1: latch addr, wdata and we into sram_addr/sram_dq_out/op register; go to SETUP. Otherwise stay in IDLE.
- SETUP (1 cycle): ce_n = 0. dq_oe = 1 if store. Load counter with WAIT_CYCLES-1. Go to STROBE.
- STROBE (WAIT_CYCLES cycles): ce_n = 0. we_n = 0 if store, else oe_n = 0. Counter decrements each cycle. When counter = 0: go to HOLD, and for a load capture sram_dq_in into rdata on that edge.
- HOLD (1 cycle): we_n/oe_n = 1; ce_n = 0; dq_oe held for store (data hold time); done = 1. Go to IDLE.
- Strobes are registered outputs matching the current state; no glitches.
- stall = req_valid & ~done.
- Timing, cycle 0 = IDLE with req_valid:
  - SETUP at 1, STROBE at 2..WAIT_CYCLES+1, HOLD/done at WAIT_CYCLES+2.
  - stall high for cycles 0..WAIT_CYCLES+1 (WAIT_CYCLES+2 stall cycles total).
- Back-to-back: the pipeline advances on the done cycle. The new request is seen in IDLE at WAIT_CYCLES+3; there is no extra bubble beyond that.
- rdata holds its value until the next load completes; stores leave rdata unchanged.
- req_valid deasserting mid-access (flush): the access still completes through HOLD and done pulses. This guarantees no truncated SRAM write.
- Request inputs are ignored outside IDLE; the latched copies drive the bus.
- rst in any state: next edge returns to reset values. A strobe in progress is deasserted and done is not pulsed.
- sram_dq_oe and sram_oe_n are never both active in the same cycle.

Test Plan:
- Reset: rst = 1 for 2 cycles with req_valid = 1 -> all outputs at reset values, stall = 0, ce_n/oe_n/we_n = 1.
- Store, WAIT_CYCLES = 1: addr = 0x1234, wdata = 0xBEEF, we = 1 -> we_n low exactly cycle 2; dq_oe = 1 for cycles 1-3; sram_addr = 0x1234; done at cycle 3; stall high for cycles 0-2.
- Load, WAIT_CYCLES = 3: addr = 0x00F0, model returns 0xA5C3 -> oe_n low cycles 2-4; done at cycle 5; rdata = 0xA5C3 from cycle 5 and held afterwards.
- Back-to-back store 0x0010 ← 0x1111 then load 0x0010: second access starts in the cycle after done; load returns 0x1111; dq_oe and oe_n never overlap.
- Reset mid-STROBE of a store: rst at cycle 2 -> cycle 3 shows we_n = 1, ce_n = 1, dq_oe = 0, no done pulse, state IDLE.
- Flush: req_valid dropped during SETUP -> STROBE/HOLD still complete and done pulses; a new request is accepted only once IDLE is reached.
